// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - single-clock FIFO over an inferred dual-port array with occupancy flags
module fifo_sync_ram #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_Wr_DV,
    input  logic [WIDTH-1:0]             i_Wr_Data,
    output logic                         o_Full,
    output logic                         o_AF_Flag,
    output logic                         o_Overflow,
    input  logic                         i_Rd_En,
    output logic                         o_Rd_DV,
    output logic [WIDTH-1:0]             o_Rd_Data,
    output logic                         o_Empty,
    output logic                         o_AE_Flag,
    output logic                         o_Underflow,
    output logic [$clog2(DEPTH+1)-1:0]   o_Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Flags come only from the registered count; request inputs never reach them.
    assign o_Full    = (o_Count == CW'(DEPTH));
    assign o_Empty   = (o_Count == '0);
    assign o_AF_Flag = (o_Count >= CW'(AF_LEVEL));
    assign o_AE_Flag = (o_Count <= CW'(AE_LEVEL));

    assign wr_ok = i_Wr_DV && !o_Full;
    assign rd_ok = i_Rd_En && !o_Empty;

    always_ff @(posedge i_Clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_Count     <= '0;
            o_Rd_DV     <= 1'b0;
            o_Rd_Data   <= '0;
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
        end else begin
            o_Rd_DV     <= rd_ok;
            o_Overflow  <= i_Wr_DV && o_Full;
            o_Underflow <= i_Rd_En && o_Empty;
            if (wr_ok) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr    <= bump(rd_ptr);
                o_Rd_Data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   o_Count <= o_Count + CW'(1);
                2'b01:   o_Count <= o_Count - CW'(1);
                default: o_Count <= o_Count;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_sync_ram.sv
// tb/tb_fifo_sync_ram.sv - directed bench over DEPTH=4, DEPTH=5 and DEPTH=8 (AF=6, AE=2) instances
module tb_fifo_sync_ram;
    logic       clk;
    logic       rst_n;
    logic       wr_dv   [3];
    logic [7:0] wr_data [3];
    logic       rd_en   [3];
    logic [7:0] rd_data [3];
    logic       full    [3];
    logic       af      [3];
    logic       ovf     [3];
    logic       rd_dv   [3];
    logic       empty   [3];
    logic       ae      [3];
    logic       unf     [3];
    logic [3:0] cnt     [3];
    logic [2:0] c0;
    logic [2:0] c1;
    logic [3:0] c2;

    int checks   = 0;
    int failures = 0;

    assign cnt[0] = {1'b0, c0};
    assign cnt[1] = {1'b0, c1};
    assign cnt[2] = c2;

    fifo_sync_ram #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv[0]), .i_Wr_Data(wr_data[0]),
        .o_Full(full[0]), .o_AF_Flag(af[0]), .o_Overflow(ovf[0]), .i_Rd_En(rd_en[0]),
        .o_Rd_DV(rd_dv[0]), .o_Rd_Data(rd_data[0]), .o_Empty(empty[0]), .o_AE_Flag(ae[0]),
        .o_Underflow(unf[0]), .o_Count(c0)
    );

    fifo_sync_ram #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv[1]), .i_Wr_Data(wr_data[1]),
        .o_Full(full[1]), .o_AF_Flag(af[1]), .o_Overflow(ovf[1]), .i_Rd_En(rd_en[1]),
        .o_Rd_DV(rd_dv[1]), .o_Rd_Data(rd_data[1]), .o_Empty(empty[1]), .o_AE_Flag(ae[1]),
        .o_Underflow(unf[1]), .o_Count(c1)
    );

    fifo_sync_ram #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_d8 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_dv[2]), .i_Wr_Data(wr_data[2]),
        .o_Full(full[2]), .o_AF_Flag(af[2]), .o_Overflow(ovf[2]), .i_Rd_En(rd_en[2]),
        .o_Rd_DV(rd_dv[2]), .o_Rd_Data(rd_data[2]), .o_Empty(empty[2]), .o_AE_Flag(ae[2]),
        .o_Underflow(unf[2]), .o_Count(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DEPTH=5 schedule after a 2-word prefill: {wr, rd} per cycle, count stays within 2..4
    logic [1:0] sched [12] = '{2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11,
                               2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_rd;
        logic       pend;
        int         mcnt;
        int         nwr;
        logic [7:0] t1 [3] = '{8'h11, 8'h22, 8'h33};

        for (int i = 0; i < 3; i++) begin
            wr_dv[i] = 1'b0; rd_en[i] = 1'b0; wr_data[i] = 8'h00;
        end
        rst_n = 1'b0;
        step();
        step();

        // reset state
        check("rst_count", cnt[2], 0);
        check("rst_empty", empty[2], 1);
        check("rst_full", full[2], 0);
        check("rst_ae", ae[2], 1);
        check("rst_af", af[2], 0);
        check("rst_rd_dv", rd_dv[2], 0);
        check("rst_rd_data", rd_data[2], 0);
        check("rst_ovf", ovf[2], 0);
        check("rst_unf", unf[2], 0);
        rst_n = 1'b1;
        step();

        // basic write 3, read 3
        for (int k = 0; k < 3; k++) begin
            wr_dv[2] = 1'b1; wr_data[2] = t1[k];
            step();
            check("t1_wr_count", cnt[2], k + 1);
        end
        wr_dv[2] = 1'b0;
        rd_en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1_rd_dv", rd_dv[2], 1);
            check("t1_rd_data", rd_data[2], t1[k]);
            check("t1_rd_count", cnt[2], 2 - k);
        end
        rd_en[2] = 1'b0;
        step();
        check("t1_dv_low", rd_dv[2], 0);
        check("t1_empty", empty[2], 1);
        check("t1_data_hold", rd_data[2], 8'h33);

        // DEPTH=4 overflow
        wr_dv[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wr_data[0] = 8'(k);
            step();
            check("t2_count", cnt[0], (k < 4) ? k : 4);
            check("t2_full", full[0], (k >= 4) ? 1 : 0);
            check("t2_ovf", ovf[0], (k == 5) ? 1 : 0);
        end
        wr_dv[0] = 1'b0;
        rd_en[0] = 1'b1;
        step();
        check("t2_ovf_one_cycle", ovf[0], 0);
        check("t2_rd1", rd_data[0], 1);
        for (int k = 2; k <= 4; k++) begin
            step();
            check("t2_rd_dv", rd_dv[0], 1);
            check("t2_rd", rd_data[0], k);
        end
        check("t2_empty", empty[0], 1);
        step();
        check("t2_extra_dv", rd_dv[0], 0);
        check("t2_extra_unf", unf[0], 1);
        check("t2_extra_hold", rd_data[0], 4);
        rd_en[0] = 1'b0;

        // simultaneous write+read on empty
        wr_dv[2] = 1'b1; rd_en[2] = 1'b1; wr_data[2] = 8'hA5;
        step();
        check("t3_rd_dv", rd_dv[2], 0);
        check("t3_unf", unf[2], 1);
        check("t3_count", cnt[2], 1);
        wr_dv[2] = 1'b0;
        step();
        check("t3_rd_dv2", rd_dv[2], 1);
        check("t3_data", rd_data[2], 8'hA5);
        check("t3_unf2", unf[2], 0);
        check("t3_count2", cnt[2], 0);
        rd_en[2] = 1'b0;

        // DEPTH=5 wrap with a scoreboard
        mcnt = 0; nwr = 0; pend = 1'b0; exp_rd = 8'h00;
        for (int c = 0; c < 2 + 12 + 4; c++) begin
            logic w, r;
            if (c < 2) begin
                w = 1'b1; r = 1'b0;
            end else if (c < 14) begin
                w = sched[c-2][1]; r = sched[c-2][0];
            end else begin
                w = 1'b0; r = 1'b1;
            end
            wr_dv[1] = w; rd_en[1] = r;
            wr_data[1] = 8'(8'h07 + nwr * 8'h13);
            if (r && mcnt > 0) begin
                exp_rd = q.pop_front();
                pend   = 1'b1;
                mcnt--;
            end else begin
                pend = 1'b0;
            end
            if (w && mcnt < 5) begin
                q.push_back(wr_data[1]);
                nwr++;
                mcnt++;
            end
            step();
            check("t4_count", cnt[1], mcnt);
            check("t4_rd_dv", rd_dv[1], pend);
            if (pend) check("t4_data", rd_data[1], exp_rd);
        end
        wr_dv[1] = 1'b0; rd_en[1] = 1'b0;
        check("t4_writes", nwr, 12);
        check("t4_empty", empty[1], 1);

        // thresholds on DEPTH=8, AF=6, AE=2
        wr_dv[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wr_data[2] = 8'(8'h80 + k);
            step();
            check("t5_fill_count", cnt[2], k);
            check("t5_fill_ae", ae[2], (k <= 2) ? 1 : 0);
            check("t5_fill_af", af[2], (k >= 6) ? 1 : 0);
        end
        wr_dv[2] = 1'b0;
        check("t5_full", full[2], 1);
        rd_en[2] = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            step();
            check("t5_drain_count", cnt[2], k);
            check("t5_drain_ae", ae[2], (k <= 2) ? 1 : 0);
            check("t5_drain_af", af[2], (k >= 6) ? 1 : 0);
            check("t5_drain_data", rd_data[2], 8'h80 + (8 - k));
        end
        rd_en[2] = 1'b0;

        // asynchronous reset mid-read
        wr_dv[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_data[2] = 8'(8'h40 + k);
            step();
        end
        wr_dv[2] = 1'b0;
        check("t6_count_pre", cnt[2], 3);
        rd_en[2] = 1'b1;
        step();
        check("t6_rd_dv_pre", rd_dv[2], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_dv", rd_dv[2], 0);
        check("t6_async_count", cnt[2], 0);
        check("t6_async_empty", empty[2], 1);
        step();
        check("t6_held_dv", rd_dv[2], 0);
        rst_n = 1'b1;
        step();
        check("t6_post_dv", rd_dv[2], 0);
        check("t6_post_unf", unf[2], 1);
        check("t6_post_count", cnt[2], 0);
        rd_en[2] = 1'b0;
        step();
        check("t6_unf_clear", unf[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
